lfsr_gen: RTL
=============

// Module: lfsr_gen
// PURPOSE
//   Parametrised successor to the fixed 32-bit lfsr: WIDTH-bit LFSR with runtime Fibonacci/Galois
//   mode, step enable, seed load with zero-lock protection, and a period monitor.
//   Serves as the pseudo-random source for the tile's test-pattern and scrambler logic.
// PARAMETERS
//   WIDTH  32            state width, >= 3
//   TAPS   32'h80200003  polynomial; bit i set = term x^(i+1); bit WIDTH-1 must be 1
//   SEED   32'h00000001  reset/fallback state; must be nonzero
//   CNT_W  32            width of step counter and period register
// PORTS
//   clk          in   1       clock
//   rst          in   1       synchronous reset, active high
//   en           in   1       advance state one step this cycle
//   mode         in   1       0 = Fibonacci, 1 = Galois
//   load         in   1       load load_val as new state and start value
//   load_val     in   WIDTH   value to load
//   out          out  WIDTH   current state, registered
//   bit_out      out  1       out[WIDTH-1], serial output
//   wrap         out  1       1-cycle pulse: state returned to start value
//   period       out  CNT_W   steps in last completed cycle
//   period_valid out  1       period holds a measured value
//   lockup       out  1       1-cycle pulse: zero load was rejected
// BEHAVIOUR
//   Clocking and reset
//   - One clock domain; all outputs registered.
//   - Reset values:
//     - out = SEED, start = SEED
//     - step_cnt = 0, period = 0
//     - period_valid = 0, wrap = 0, lockup = 0
//   Priority: rst > load > en > hold.
//   Fibonacci step: fb = ^(out & TAPS); next = {out[WIDTH-2:0], fb}.
//   Galois step:
//   - G = {TAPS[WIDTH-2:0], 1'b1}
//   - next = {out[WIDTH-2:0], 1'b0} ^ (out[WIDTH-1] ? G : 0)
//   - Both modes generate the same maximal sequence length for a primitive TAPS.
//   Timing
//   - en sampled high at edge k: out shows next at edge k, i.e. 1-cycle latency.
//   - en low: out, step_cnt and all flags hold; wrap and lockup deassert.
//   Load
//   - load_val != 0: out = start = load_val; step_cnt = 0; period_valid = 0.
//   - load_val == 0: out = start = SEED, the other load effects apply, and lockup pulses for 1 cycle.
//   - load together with en: load wins and no step is taken.
//   Step counting
//   - Each step: step_cnt += 1, saturating at all-ones.
//   - If next == start:
//     - wrap pulses on the same edge that out updates
//     - period = step_cnt + 1, saturating
//     - period_valid = 1
//     - step_cnt = 0
//   Runtime changes
//   - mode change takes effect on the next step; state is not reset and start is unchanged.
//   - wrap can then be delayed, or never occur if start is not on the new orbit.
//   - rst mid-sequence restores SEED immediately, overriding load and en.
// TESTING (WIDTH=4, TAPS=4'hC, SEED=4'h1, CNT_W=8)
//   1 rst 1 cycle, then en=1 in Fibonacci mode -> out 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1;
//     wrap on the return to 1, period = 15, period_valid = 1.
//   2 rst, then mode=1, en=1 -> out 1,2,4,8,9,B,F,7,...;
//     after 15 steps out = 1, wrap pulses, period = 15.
//   3 load=1 with load_val=4'h0 -> out = 1, lockup pulses 1 cycle, step_cnt = 0, period_valid = 0.
//   4 load=1, load_val=4'h6, en=1 in the same cycle -> out = 6 with no step;
//     15 later steps -> wrap with out = 6.
//   5 en toggles 1,0,1 from reset -> out 2, holds at 2, then 4; wrap and lockup stay 0.
//   6 rst asserted mid-run (out = B) with load=1 -> next out = 1, all flags and counters cleared.

Source files
------------

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and observation bundle for lfsr_gen.
//   master : drives en/mode/load/load_val, observes the generator outputs
//   slave  : the generator itself
//   en, mode, load, load_val   step enable, 0=Fibonacci/1=Galois, seed load, seed value
//   out, bit_out               current state and its MSB
//   wrap, lockup               1-cycle pulses: returned to start / zero load rejected
//   period, period_valid       length of last completed cycle, and whether it is measured
interface lfsr_gen_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    logic             en;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             bit_out;
    logic             wrap;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             lockup;

    modport master (
        output en, mode, load, load_val,
        input  out, bit_out, wrap, period, period_valid, lockup
    );

    modport slave (
        input  en, mode, load, load_val,
        output out, bit_out, wrap, period, period_valid, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: WIDTH-bit LFSR with runtime Fibonacci/Galois selection, step enable,
// seed load with zero-lock protection and a period monitor.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lfsr_gen_if.slave (controls in, state/flags/period out, all registered)
module lfsr_gen #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h00000001),
    parameter int               CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    lfsr_gen_if.slave bus
);
    // Galois feedback mask: term x^(i+1) of TAPS acts on bit i+1 after the shift,
    // and the constant term always feeds bit 0.
    localparam logic [WIDTH-1:0] GMASK = {TAPS[WIDTH-2:0], 1'b1};

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] start;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             wrap;
    logic             lockup;

    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] next;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        fib_next = {state[WIDTH-2:0], ^(state & TAPS)};
        gal_next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GMASK : '0);
        next     = bus.mode ? gal_next : fib_next;
        // step count + 1, sticking at all-ones instead of wrapping
        cnt_inc  = (&step_cnt) ? step_cnt : step_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEED;
            start        <= SEED;
            step_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            lockup       <= 1'b0;
        end else if (bus.load) begin
            // an all-zero state would never leave zero, so fall back to SEED and flag it
            state        <= (bus.load_val == '0) ? SEED : bus.load_val;
            start        <= (bus.load_val == '0) ? SEED : bus.load_val;
            step_cnt     <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            lockup       <= (bus.load_val == '0);
        end else if (bus.en) begin
            state  <= next;
            lockup <= 1'b0;
            if (next == start) begin
                wrap         <= 1'b1;
                period       <= cnt_inc;
                period_valid <= 1'b1;
                step_cnt     <= '0;
            end else begin
                wrap     <= 1'b0;
                step_cnt <= cnt_inc;
            end
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end
    end

    assign bus.out          = state;
    assign bus.bit_out      = state[WIDTH-1];
    assign bus.wrap         = wrap;
    assign bus.period       = period;
    assign bus.period_valid = period_valid;
    assign bus.lockup       = lockup;
endmodule
